// File: rtl/tt_pkg.sv
// ---------------------------------------------------------------------------
// tt_pkg -- shared definitions for the truth-table sequencer.
//   tt_state_e   : sequencer FSM state encoding
//   TT_NPAT      : number of input patterns in one sweep ({a,b} = 00..11)
//   TT_DWELL_DEF : default number of cycles each pattern is held
// ---------------------------------------------------------------------------
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_FIN   = 2'd2
  } tt_state_e;

  localparam int TT_NPAT      = 4;
  localparam int TT_DWELL_DEF = 8;

endpackage

// File: rtl/tt_dwell_cnt.sv
// ---------------------------------------------------------------------------
// tt_dwell_cnt -- dwell counter for the truth-table sequencer.
// Counts 0..DWELL-1 while enabled and returns to 0 after the terminal value,
// so it never wraps through its full range.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset (count <= 0)
//   i_load  : synchronous clear to 0 (start of a sweep)
//   i_en    : advance the count this cycle
//   o_term  : count is at DWELL-1 (decoded from the registered count)
// ---------------------------------------------------------------------------
module tt_dwell_cnt #(
  parameter int DWELL = 8,
  parameter int CNT_W = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_term
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_term ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_term = (r_cnt == TERM_VAL);

endmodule

// File: rtl/tt_sequencer.sv
// ---------------------------------------------------------------------------
// tt_sequencer -- drives a 2-input combinational block through all four
// input patterns, holding each for DWELL cycles, captures the response c
// at the last cycle of each pattern and compares the captured truth table
// against an expected table latched at start.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : pulse, begins a sweep when idle (ignored while busy)
//   exp_tt[3:0]: expected truth table, bit i for pattern i = {a,b}
//   c         : response of the block under test
//   a, b      : pattern drive (index bit 1 / bit 0), 0 when not sweeping
//   busy      : sweep in progress (DRIVE or FIN)
//   done      : one-cycle pulse in the final cycle of a sweep
//   tt[3:0]   : captured truth table
//   tt_valid  : tt holds a complete sweep result
//   mismatch  : tt differs from the latched expectation, while tt_valid
//   dbg_state : current FSM state
// Handshake: start is a level sampled on each rising edge; it is accepted
// only in IDLE, and any start seen in DRIVE or FIN has no effect.
// All outputs come from registered state; c only feeds the tt register.
// ---------------------------------------------------------------------------
module tt_sequencer
  import tt_pkg::*;
#(
  parameter int DWELL = TT_DWELL_DEF,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] exp_tt,
  input  logic       c,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [3:0] tt,
  output logic       tt_valid,
  output logic       mismatch,
  output tt_state_e  dbg_state
);

  localparam logic [1:0] LAST_IDX = 2'(TT_NPAT - 1);

  tt_state_e  r_state;
  logic [1:0] r_idx;
  logic [3:0] r_tt;
  logic [3:0] r_exp;
  logic       r_tt_valid;

  logic w_accept;
  logic w_term;

  assign w_accept = (r_state == ST_IDLE) && start;

  tt_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_accept),
    .i_en   (r_state == ST_DRIVE),
    .o_term (w_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_tt       <= '0;
      r_exp      <= '0;
      r_tt_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_DRIVE;
            r_idx      <= '0;
            r_tt       <= '0;
            r_exp      <= exp_tt;
            r_tt_valid <= 1'b0;
          end
        end
        ST_DRIVE: begin
          // Capture c on the last dwell cycle of the current pattern.
          if (w_term) begin
            r_tt[r_idx] <= c;
            if (r_idx == LAST_IDX) begin
              r_state    <= ST_FIN;
              // Valid together with done so mismatch is usable in FIN.
              r_tt_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign a         = (r_state == ST_DRIVE) & r_idx[1];
  assign b         = (r_state == ST_DRIVE) & r_idx[0];
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FIN);
  assign tt        = r_tt;
  assign tt_valid  = r_tt_valid;
  assign mismatch  = r_tt_valid && (r_tt != r_exp);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tt_sequencer -- directed bench for tt_sequencer.
// Two instances: u_dut8 (DWELL=8) and u_dut1 (DWELL=1). Each drives a small
// combinational gate model selected by gate8/gate1 (0=AND, 1=XOR, 2=OR).
// Timing reference: the edge that samples start is edge N; after edge N+k
// the pattern is k/DWELL for k < 4*DWELL, FIN (done=1) is seen after edge
// N+4*DWELL and the sequencer is back in IDLE after edge N+4*DWELL+1.
// ---------------------------------------------------------------------------
module tb_tt_sequencer;
  import tt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drv_start = 1'b0;
  int   dsel = 0;          // 0 -> u_dut8, 1 -> u_dut1
  int   gate8 = 0;
  int   gate1 = 0;
  logic [3:0] exp8 = '0;
  logic [3:0] exp1 = '0;

  logic start8, start1, c8, c1;
  logic a8, b8, busy8, done8, tv8, mm8;
  logic a1, b1, busy1, done1, tv1, mm1;
  logic [3:0] tt8, tt1;
  tt_state_e st8, st1;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs and gate models ----------------
  assign start8 = drv_start && (dsel == 0);
  assign start1 = drv_start && (dsel == 1);

  function automatic logic gate_fn(input int g, input logic x, input logic y);
    case (g)
      0:       return x & y;
      1:       return x ^ y;
      default: return x | y;
    endcase
  endfunction

  always_comb c8 = gate_fn(gate8, a8, b8);
  always_comb c1 = gate_fn(gate1, a1, b1);

  tt_sequencer #(.DWELL(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .exp_tt(exp8), .c(c8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .tt(tt8),
    .tt_valid(tv8), .mismatch(mm8), .dbg_state(st8)
  );

  tt_sequencer #(.DWELL(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .exp_tt(exp1), .c(c1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .tt(tt1),
    .tt_valid(tv1), .mismatch(mm1), .dbg_state(st1)
  );

  // Observed signals of the selected instance.
  logic [1:0] m_ab;
  logic       m_busy, m_done, m_tv, m_mm;
  logic [3:0] m_tt;
  always_comb begin
    m_ab   = (dsel == 0) ? {a8, b8} : {a1, b1};
    m_busy = (dsel == 0) ? busy8 : busy1;
    m_done = (dsel == 0) ? done8 : done1;
    m_tv   = (dsel == 0) ? tv8 : tv1;
    m_mm   = (dsel == 0) ? mm8 : mm1;
    m_tt   = (dsel == 0) ? tt8 : tt1;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One sweep on the selected instance. s1/s2: step indices k at which an
  // extra start pulse is presented (sampled by edge N+k); -1 for none.
  // exp_live: exp_tt value applied after acceptance (must not matter).
  task automatic sweep(input int d, input logic [3:0] want_tt, input logic want_mm,
                       input int s1, input int s2, input logic [3:0] exp_live);
    logic [3:0] exp_tt_v;
    exp_q.push_back(want_tt);
    drv_start = 1'b1;
    tick();                       // edge N
    drv_start = 1'b0;
    if (dsel == 0) exp8 = exp_live; else exp1 = exp_live;
    chk("accept_busy", {7'd0, m_busy}, 8'd1);
    chk("accept_ab", {6'd0, m_ab}, 8'd0);
    chk("accept_tv", {7'd0, m_tv}, 8'd0);
    for (int k = 1; k <= 4 * d + 1; k++) begin
      drv_start = (k == s1) || (k == s2);
      tick();                     // edge N+k
      drv_start = 1'b0;
      if (k < 4 * d) begin
        chk($sformatf("ab_k%0d", k), {6'd0, m_ab}, 8'(k / d));
        chk($sformatf("busy_k%0d", k), {7'd0, m_busy}, 8'd1);
        chk($sformatf("done_k%0d", k), {7'd0, m_done}, 8'd0);
      end else if (k == 4 * d) begin
        exp_tt_v = exp_q.pop_front();
        chk("fin_done", {7'd0, m_done}, 8'd1);
        chk("fin_busy", {7'd0, m_busy}, 8'd1);
        chk("fin_ab", {6'd0, m_ab}, 8'd0);
        chk("fin_tt", {4'd0, m_tt}, {4'd0, exp_tt_v});
        chk("fin_tv", {7'd0, m_tv}, 8'd1);
        chk("fin_mm", {7'd0, m_mm}, {7'd0, want_mm});
      end else begin
        chk("idle_done", {7'd0, m_done}, 8'd0);
        chk("idle_busy", {7'd0, m_busy}, 8'd0);
        chk("idle_tv", {7'd0, m_tv}, 8'd1);
        chk("idle_tt", {4'd0, m_tt}, {4'd0, want_tt});
        chk("idle_mm", {7'd0, m_mm}, {7'd0, want_mm});
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ab"}, {6'd0, m_ab}, 8'd0);
    chk({tag, "_busy"}, {7'd0, m_busy}, 8'd0);
    chk({tag, "_done"}, {7'd0, m_done}, 8'd0);
    chk({tag, "_tt"}, {4'd0, m_tt}, 8'd0);
    chk({tag, "_tv"}, {7'd0, m_tv}, 8'd0);
    chk({tag, "_mm"}, {7'd0, m_mm}, 8'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    dsel = 0; chk_all_zero("rst8");
    dsel = 1; chk_all_zero("rst1");

    // AND gate, expected 1000: match.
    dsel = 0; gate8 = 0; exp8 = 4'b1000;
    sweep(8, 4'b1000, 1'b0, -1, -1, 4'b1000);

    // XOR gate, expected 1000 latched; live exp_tt changed to 0110 afterwards.
    gate8 = 1; exp8 = 4'b1000;
    sweep(8, 4'b0110, 1'b1, -1, -1, 4'b0110);

    // Extra start pulses during the sweep are ignored.
    gate8 = 0; exp8 = 4'b1000;
    sweep(8, 4'b1000, 1'b0, 3, 10, 4'b1000);

    // Reset mid-sweep (after edge N+12), then a fresh sweep.
    gate8 = 2; exp8 = 4'b1110;
    drv_start = 1'b1;
    tick();
    drv_start = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    chk("pre_rst_busy", {7'd0, m_busy}, 8'd1);
    chk("pre_rst_ab", {6'd0, m_ab}, 8'd1);
    rst = 1'b1;
    drv_start = 1'b1;             // rst wins over a simultaneous start
    tick();
    rst = 1'b0;
    drv_start = 1'b0;
    chk_all_zero("mid_rst");
    for (int k = 0; k < 40; k++) begin
      tick();
      chk($sformatf("no_done_%0d", k), {7'd0, m_done}, 8'd0);
    end
    sweep(8, 4'b1110, 1'b0, -1, -1, 4'b1110);

    // DWELL=1, OR gate: done after edge N+4 (observed at start+5).
    dsel = 1; gate1 = 2; exp1 = 4'b1110;
    sweep(1, 4'b1110, 1'b0, -1, -1, 4'b1110);

    // Start held high: back-to-back sweeps with one IDLE cycle between.
    gate1 = 0; exp1 = 4'b0001;
    drv_start = 1'b1;
    tick();                       // edge N: accepted
    chk("held_tv_clr", {7'd0, m_tv}, 8'd0);
    chk("held_tt_clr", {4'd0, m_tt}, 8'd0);
    for (int k = 1; k <= 3; k++) tick();
    chk("held_ab3", {6'd0, m_ab}, 8'd3);
    tick();                       // N+4: FIN, start ignored
    chk("held_fin_done", {7'd0, m_done}, 8'd1);
    chk("held_fin_tt", {4'd0, m_tt}, 8'b1000);
    chk("held_fin_mm", {7'd0, m_mm}, 8'd1);
    tick();                       // N+5: IDLE
    chk("held_idle_busy", {7'd0, m_busy}, 8'd0);
    chk("held_idle_tv", {7'd0, m_tv}, 8'd1);
    tick();                       // N+6: re-accepted
    chk("held_re_busy", {7'd0, m_busy}, 8'd1);
    chk("held_re_tv", {7'd0, m_tv}, 8'd0);
    chk("held_re_mm", {7'd0, m_mm}, 8'd0);
    for (int k = 1; k <= 4; k++) tick();
    chk("held_fin2_done", {7'd0, m_done}, 8'd1);
    chk("held_fin2_tv", {7'd0, m_tv}, 8'd1);
    drv_start = 1'b0;
    tick();
    tick();
    chk("held_end_busy", {7'd0, m_busy}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tt_sequencer.md
TT_SEQUENCER -- requirements
Module: tt_sequencer

Interface
REQ-001 Parameter DWELL, default 8: cycles each input pattern is held; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: dwell counter width; SHALL hold DWELL-1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  pulse; begins one truth-table sweep when idle.
REQ-006 exp_tt  input  4  expected response; bit i is the expected c for pattern i = {a,b}.
REQ-007 c  input  1  response from the downstream 2-input DUT; combinational in a,b.
REQ-008 a  output  1  DUT input a; equals pattern index bit 1.
REQ-009 b  output  1  DUT input b; equals pattern index bit 0.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 tt  output  4  captured response; bit i is c sampled under pattern i.
REQ-013 tt_valid  output  1  high from done until the next accepted start or reset.
REQ-014 mismatch  output  1  (tt != exp_tt), qualified by tt_valid; 0 otherwise.

Function
REQ-015 FSM states IDLE, DRIVE, FIN; encoding is an enumerated type.
REQ-016 IDLE: start=1 -> DRIVE, idx<=0, cnt<=0, tt<=0, tt_valid<=0, exp latched into an internal register.
REQ-017 IDLE: start=0 -> stay in IDLE; a, b hold 0.
REQ-018 DRIVE: a,b driven from registered idx; cnt increments by 1 each cycle.
REQ-019 DRIVE: when cnt==DWELL-1, tt[idx]<=c at that edge; then cnt<=0.
REQ-020 DRIVE: at cnt==DWELL-1, if idx<3 then idx<=idx+1, otherwise -> FIN.
REQ-021 Sweep order SHALL be {a,b} = 00, 01, 10, 11; each pattern held exactly DWELL cycles.
REQ-022 FIN: lasts exactly one cycle; done=1, tt_valid<=1, a=b=0; then -> IDLE.
REQ-023 busy=1 in DRIVE and FIN only.
REQ-024 start while busy SHALL be ignored and does not restart or extend the sweep.
REQ-025 start in the FIN cycle is ignored; start in the first IDLE cycle after FIN is accepted.
REQ-026 Latency: start accepted at edge N -> done high during cycle N+4*DWELL+1.
REQ-027 DWELL=1: each pattern is held one cycle and c is sampled on that same cycle's edge.
REQ-028 mismatch compares tt against the exp_tt value latched at start, not the live input.
REQ-029 cnt and idx SHALL never wrap; terminal values force a transition.

Reset
REQ-030 rst=1 at any clock edge -> IDLE, idx=0, cnt=0, tt=0, tt_valid=0, done=0, busy=0, a=0, b=0, mismatch=0.
REQ-031 rst in the middle of a sweep aborts it without asserting done; partial tt is cleared.
REQ-032 rst takes precedence over a simultaneous start.

Structure
REQ-033 Shared package tt_pkg SHALL hold: state enum, pattern count constant (4), and the default DWELL.
REQ-034 Sub-module tt_dwell_cnt SHALL provide the counter (load, enable, terminal flag); everything else stays flat.
REQ-035 Outputs a, b, busy, done, tt, tt_valid SHALL be registered or decoded from registered state only; no path from c to any output.

Verification
REQ-036 Stimulus: DWELL=8, DUT=AND, exp_tt=4'b1000, start pulse. Required: a,b steps 00/01/10/11 at 8-cycle spacing; done at start+33; tt=1000; mismatch=0.
REQ-037 Stimulus: DUT=XOR, exp_tt=4'b1000. Required: tt=0110; mismatch=1 while tt_valid is high.
REQ-038 Stimulus: start pulses at cycles 3 and 10 of a sweep. Required: both ignored; done occurs once, at the original time.
REQ-039 Stimulus: rst asserted at cycle 12 of a sweep, then start. Required: all outputs 0 the cycle after rst; no done from the aborted sweep; new sweep completes normally.
REQ-040 Stimulus: DWELL=1, DUT=OR, start. Required: done at start+5; tt=1110.
REQ-041 Stimulus: start held high continuously. Required: back-to-back sweeps with one IDLE cycle between them; tt_valid drops on each re-accept.
